// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet TX path.
// Scheduler states, word width and timing defaults live here.
package eth_pkg;

    localparam int ETH_WORD_W        = 32;
    localparam int DEF_IFG_CYCLES    = 12;
    localparam int DEF_START_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE,
        IFG
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The pointer moves past the winner only when the caller advances.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N-1:0]                     i_req,
    input  logic                             i_advance,
    output logic [N-1:0]                     o_grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_index
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = IW + 1;

    logic [IW-1:0] r_ptr;
    logic [SW-1:0] w_sum;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_index;
    logic          w_found;

    // Scan requesters starting at the pointer and pick the first active one
    always_comb begin
        w_grant = '0;
        w_index = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + SW'(i);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            if (!w_found && i_req[w_sum[IW-1:0]]) begin
                w_found                 = 1'b1;
                w_grant[w_sum[IW-1:0]] = 1'b1;
                w_index                 = w_sum[IW-1:0];
            end
        end
    end

    // Move the pointer one past the winner on an accepted grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            if (w_index == IW'(N - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_index + IW'(1);
            end
        end
    end

    assign o_grant = w_grant;
    assign o_index = w_index;

endmodule

// File: rtl/eth_tx_scheduler.sv
// Shares the single TX MAC among several requesters, one frame per grant.
// Tracks MAC busy, enforces the inter-frame gap and flags start timeouts.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ETH_WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          tx_err,
    output logic [ETH_WORD_W-1:0]         mac_data,
    output logic                          mac_dval,
    input  logic                          mac_busy,
    output logic [15:0]                   frames_sent
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(max_int(IFG_CYCLES, START_TIMEOUT)) + 1;

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IW-1:0]         r_win;
    logic [IW-1:0]         w_win_nxt;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    w_gnt_nxt;
    logic [NUM_REQ-1:0]    r_done;
    logic [NUM_REQ-1:0]    w_done_nxt;
    logic                  r_tx_err;
    logic                  w_tx_err_nxt;
    logic                  r_dval;
    logic                  w_dval_nxt;
    logic [ETH_WORD_W-1:0] r_data;
    logic [ETH_WORD_W-1:0] w_data_nxt;
    logic [15:0]           r_frames_sent;
    logic [15:0]           w_frames_nxt;

    logic [NUM_REQ-1:0]    w_arb_grant;
    logic [IW-1:0]         w_arb_index;
    logic                  w_launch;

    // A stale busy from the MAC blocks any new launch
    assign w_launch = (r_state == IDLE) && (|req) && !mac_busy;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_advance (w_launch),
        .o_grant   (w_arb_grant),
        .o_index   (w_arb_index)
    );

    // Next-state and next-output logic for the launch/complete/gap sequence
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_win_nxt    = r_win;
        w_gnt_nxt    = '0;
        w_done_nxt   = '0;
        w_tx_err_nxt = 1'b0;
        w_dval_nxt   = 1'b0;
        w_data_nxt   = r_data;
        w_frames_nxt = r_frames_sent;
        unique case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_data_nxt  = req_data[int'(w_arb_index)*ETH_WORD_W +: ETH_WORD_W];
                    w_dval_nxt  = 1'b1;
                    w_gnt_nxt   = w_arb_grant;
                    w_win_nxt   = w_arb_index;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (mac_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    w_tx_err_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = IFG;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!mac_busy) begin
                    w_done_nxt[r_win] = 1'b1;
                    w_frames_nxt      = r_frames_sent + 16'd1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = IFG;
                end
            end
            IFG: begin
                if (r_cnt == CNT_W'(IFG_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_win         <= '0;
            r_gnt         <= '0;
            r_done        <= '0;
            r_tx_err      <= 1'b0;
            r_dval        <= 1'b0;
            r_data        <= '0;
            r_frames_sent <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_win         <= w_win_nxt;
            r_gnt         <= w_gnt_nxt;
            r_done        <= w_done_nxt;
            r_tx_err      <= w_tx_err_nxt;
            r_dval        <= w_dval_nxt;
            r_data        <= w_data_nxt;
            r_frames_sent <= w_frames_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign tx_err      = r_tx_err;
    assign mac_data    = r_data;
    assign mac_dval    = r_dval;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with a behavioural MAC busy model.
// Vector table for arbitration plus hand sequences for timing corners.
module tb_eth_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [63:0] req_data;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        tx_err;
    logic [31:0] mac_data;
    logic        mac_dval;
    logic        mac_busy;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;

    int   busy_len   = 0;
    logic force_busy = 1'b0;
    int   bcnt       = 0;

    eth_tx_scheduler #(
        .NUM_REQ       (2),
        .IFG_CYCLES    (12),
        .START_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .tx_err      (tx_err),
        .mac_data    (mac_data),
        .mac_dval    (mac_dval),
        .mac_busy    (mac_busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // MAC model: busy for busy_len cycles starting the cycle after dval
    always @(posedge clk) begin
        if (mac_dval && busy_len > 0) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign mac_busy = force_busy || (bcnt > 0);

    typedef struct {
        logic [1:0]  req;
        int          blen;
        logic [1:0]  egnt;
        logic [31:0] edata;
        logic [1:0]  edone;
        logic        eerr;
        logic [15:0] efr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_gnt(input string nm, input int lim, output int n);
        n = 0;
        while (gnt == 2'b00 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_gnt_seen"}, 64'(gnt != 2'b00), 64'd1);
    endtask

    task automatic wait_end(input string nm, input int lim, output int n);
        n = 0;
        while (done == 2'b00 && !tx_err && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_end_seen"}, 64'((done != 2'b00) || tx_err), 64'd1);
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic bad;

        vt[0] = '{2'b01, 3, 2'b01, 32'hCAFE0001, 2'b01, 1'b0, 16'd1};
        vt[1] = '{2'b01, 2, 2'b01, 32'hCAFE0001, 2'b01, 1'b0, 16'd2};
        vt[2] = '{2'b11, 3, 2'b10, 32'hBEEF0002, 2'b10, 1'b0, 16'd3};
        vt[3] = '{2'b11, 1, 2'b01, 32'hCAFE0001, 2'b01, 1'b0, 16'd4};
        vt[4] = '{2'b10, 0, 2'b10, 32'hBEEF0002, 2'b00, 1'b1, 16'd4};
        vt[5] = '{2'b10, 4, 2'b10, 32'hBEEF0002, 2'b10, 1'b0, 16'd5};
        vt[6] = '{2'b11, 2, 2'b01, 32'hCAFE0001, 2'b01, 1'b0, 16'd6};

        rst_n    = 1'b0;
        req      = 2'b00;
        req_data = {32'hBEEF0002, 32'hCAFE0001};
        idle(3);
        chk("rst_outs", {gnt, done, tx_err, mac_dval}, 64'd0);
        chk("rst_data", 64'(mac_data), 64'd0);
        chk("rst_frames", 64'(frames_sent), 64'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            busy_len = vt[i].blen;
            req      = vt[i].req;
            wait_gnt($sformatf("vec%0d", i), 40, n);
            chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vt[i].egnt));
            chk($sformatf("vec%0d_dval", i), 64'(mac_dval), 64'd1);
            chk($sformatf("vec%0d_data", i), 64'(mac_data), 64'(vt[i].edata));
            req = 2'b00;
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), {gnt, mac_dval}, 64'd0);
            chk($sformatf("vec%0d_hold", i), 64'(mac_data), 64'(vt[i].edata));
            wait_end($sformatf("vec%0d", i), 40, n);
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].edone));
            chk($sformatf("vec%0d_err", i), 64'(tx_err), 64'(vt[i].eerr));
            chk($sformatf("vec%0d_frames", i), 64'(frames_sent), 64'(vt[i].efr));
        end

        idle(20);
        busy_len = 3;
        req      = 2'b01;
        wait_gnt("t1a", 40, n);
        wait_end("t1a", 40, n);
        chk("t1_done_lat", 64'(n), 64'd5);
        chk("t1_done", 64'(done), 64'd1);
        wait_gnt("t1b", 40, n);
        chk("t1_ifg_gap", 64'(n), 64'd13);
        req = 2'b00;
        wait_end("t1b", 40, n);
        chk("t1_frames", 64'(frames_sent), 64'd8);

        idle(20);
        busy_len = 0;
        req      = 2'b01;
        wait_gnt("t3a", 40, n);
        wait_end("t3a", 40, n);
        chk("t3_err_lat", 64'(n), 64'd16);
        chk("t3_err", {done, tx_err}, 64'd1);
        chk("t3_frames", 64'(frames_sent), 64'd8);
        busy_len = 2;
        wait_gnt("t3b", 40, n);
        chk("t3_ifg_gap", 64'(n), 64'd13);
        chk("t3_gnt", 64'(gnt), 64'd1);
        req = 2'b00;
        wait_end("t3b", 40, n);
        chk("t3_frames2", 64'(frames_sent), 64'd9);

        idle(20);
        busy_len = 0;
        req      = 2'b10;
        wait_gnt("tedge", 40, n);
        req = 2'b00;
        idle(15);
        force_busy = 1'b1;
        idle(2);
        force_busy = 1'b0;
        wait_end("tedge", 40, n);
        chk("tedge_done", {done, tx_err}, 64'b100);
        chk("tedge_frames", 64'(frames_sent), 64'd10);

        idle(20);
        busy_len   = 2;
        force_busy = 1'b1;
        req        = 2'b10;
        bad        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) bad = 1'b1;
        end
        chk("t4_no_gnt_busy", 64'(bad), 64'd0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("t4_gnt_lat", 64'(gnt), 64'b10);
        req = 2'b00;
        wait_end("t4", 40, n);
        chk("t4_frames", 64'(frames_sent), 64'd11);

        idle(20);
        busy_len = 10;
        req      = 2'b01;
        wait_gnt("t5a", 40, n);
        req = 2'b00;
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", {gnt, done, tx_err, mac_dval}, 64'd0);
        chk("t5_async_data", 64'(mac_data), 64'd0);
        chk("t5_async_frames", 64'(frames_sent), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        busy_len = 2;
        req      = 2'b11;
        wait_gnt("t5b", 40, n);
        chk("t5_ptr_restart", 64'(gnt), 64'b01);
        req = 2'b00;
        wait_end("t5b", 40, n);
        chk("t5_frames", 64'(frames_sent), 64'd1);

        idle(20);
        force dut.r_frames_sent = 16'hFFFE;
        idle(2);
        release dut.r_frames_sent;
        @(negedge clk);
        chk("t6_preload", 64'(frames_sent), 64'hFFFE);
        busy_len = 1;
        req      = 2'b01;
        wait_gnt("t6a", 40, n);
        req = 2'b00;
        wait_end("t6a", 40, n);
        chk("t6_ffff", 64'(frames_sent), 64'hFFFF);
        req = 2'b10;
        wait_gnt("t6b", 40, n);
        req = 2'b00;
        wait_end("t6b", 40, n);
        chk("t6_wrap", 64'(frames_sent), 64'd0);
        chk("t6_done", 64'(done), 64'b10);
        @(negedge clk);
        req = 2'b01;
        idle(3);
        req = 2'b00;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) bad = 1'b1;
        end
        chk("t6_ifg_drop", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
